// File: rtl/em4100_pkg.sv
// em4100_pkg: shared constants and types for the EM4100 tag transmitter
// and, later, the matching reader/decoder.
//   FRAME_BITS / HEADER_BITS / ROWS : EM4100 frame geometry
//   MODE_MANCHESTER / MODE_BIPHASE  : line-code selector values
//   state_t                         : transmitter FSM states
//   even_parity4()                  : row parity helper
package em4100_pkg;

    localparam int FRAME_BITS      = 64;
    localparam int HEADER_BITS     = 9;
    localparam int ROWS            = 10;

    localparam int MODE_MANCHESTER = 0;
    localparam int MODE_BIPHASE    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Even parity over one nibble: 1 when the nibble has an odd number of ones.
    function automatic logic even_parity4(input logic [3:0] nib);
        return ^nib;
    endfunction

endpackage

// File: rtl/em4100_frame_build.sv
// em4100_frame_build: purely combinational EM4100 frame builder.
//   data  [39:0] in  : tag ID, data[39:36] is the first row (MSB first)
//   frame [63:0] out : frame in transmit order, frame[0] is sent first
//                      [8:0] header ones, [58:9] ten rows of nibble+parity,
//                      [62:59] column parity CP3..CP0, [63] stop bit (0)
module em4100_frame_build
    import em4100_pkg::*;
(
    input  logic [39:0]           data,
    output logic [FRAME_BITS-1:0] frame
);

    assign frame[HEADER_BITS-1:0] = {HEADER_BITS{1'b1}};

    // Each row occupies five slots: nibble MSB first, then its even parity.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int BASE = HEADER_BITS + 5 * r;
        localparam int MSB  = 39 - 4 * r;
        assign frame[BASE + 0] = data[MSB];
        assign frame[BASE + 1] = data[MSB - 1];
        assign frame[BASE + 2] = data[MSB - 2];
        assign frame[BASE + 3] = data[MSB - 3];
        assign frame[BASE + 4] = even_parity4(data[MSB -: 4]);
    end

    // Column c collects nibble bit c of every row; CP3 goes out first.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [ROWS-1:0] col_bits_s;
        for (genvar r = 0; r < ROWS; r++) begin : g_bit
            assign col_bits_s[r] = data[4 * r + c];
        end
        assign frame[FRAME_BITS - 2 - c] = ^col_bits_s;
    end

    assign frame[FRAME_BITS-1] = 1'b0;

endmodule

// File: rtl/em4100_tx.sv
// em4100_tx: EM4100 tag transmitter with Manchester or biphase line code.
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   data_valid/ready  : ID load handshake, ready only in IDLE
//   data [39:0]       : tag ID, latched on load
//   abort             : synchronous stop request (wins over a load)
//   q, q_oe           : coded level and modulator enable
//   busy              : high while sending a frame or idling in the gap
//   frame_done        : one-cycle pulse on the last clock of each frame
//   frame_cnt [7:0]   : frames completed since the last load
module em4100_tx
    import em4100_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 32,
    parameter int MODE          = 0,
    parameter int REPEAT        = 0,
    parameter int GAP_BITS      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [39:0] data,
    input  logic        abort,
    output logic        q,
    output logic        q_oe,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int HALF_W   = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam int GAP_CLKS = GAP_BITS * 2 * HALF_BIT_CLKS;
    localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALF_BIT_CLKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [7:0]        REPEAT_CNT = 8'(REPEAT);

    state_t                  state_r;
    logic [39:0]             data_r;
    logic [HALF_W-1:0]       half_cnt_r;
    logic                    half_r;
    logic [5:0]              bit_r;
    logic [GAP_W-1:0]        gap_cnt_r;
    logic                    q_r;
    logic                    q_oe_r;
    logic                    busy_r;
    logic                    data_ready_r;
    logic                    frame_done_r;
    logic [7:0]              frame_cnt_r;

    logic [FRAME_BITS-1:0]   frame_s;
    logic [HALF_W-1:0]       half_cnt_n_s;
    logic                    half_n_s;
    logic [5:0]              bit_n_s;
    logic                    frame_end_s;
    logic                    next_last_s;
    logic                    reps_done_s;
    logic                    gap_end_s;
    logic                    q_code_s;

    em4100_frame_build u_frame_build (
        .data  (data_r),
        .frame (frame_s)
    );

    // Next position of the half-bit timer; bit index wraps 63 -> 0 for back-to-back frames.
    always_comb begin
        half_cnt_n_s = half_cnt_r;
        half_n_s     = half_r;
        bit_n_s      = bit_r;
        if (half_cnt_r == HALF_LAST) begin
            half_cnt_n_s = '0;
            if (half_r) begin
                half_n_s = 1'b0;
                bit_n_s  = bit_r + 6'd1;
            end else begin
                half_n_s = 1'b1;
            end
        end else begin
            half_cnt_n_s = half_cnt_r + HALF_W'(1);
        end
    end

    assign frame_end_s = (half_cnt_r == HALF_LAST) && half_r && (bit_r == 6'd63);
    assign next_last_s = (half_cnt_n_s == HALF_LAST) && half_n_s && (bit_n_s == 6'd63);
    assign reps_done_s = (REPEAT != 0) && (frame_cnt_r == REPEAT_CNT);
    assign gap_end_s   = (gap_cnt_r == GAP_LAST);

    // Line coder: level for the half-bit that starts at the next position.
    // In biphase the current q is the running level, so it is simply toggled.
    always_comb begin
        if (MODE == MODE_BIPHASE) begin
            if (!half_n_s) begin
                q_code_s = ~q_r;
            end else if (!frame_s[bit_n_s]) begin
                q_code_s = ~q_r;
            end else begin
                q_code_s = q_r;
            end
        end else begin
            q_code_s = half_n_s ? ~frame_s[bit_n_s] : frame_s[bit_n_s];
        end
    end

    // Transmitter FSM with registered outputs, timers and frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            data_r       <= 40'd0;
            half_cnt_r   <= '0;
            half_r       <= 1'b0;
            bit_r        <= 6'd0;
            gap_cnt_r    <= '0;
            q_r          <= 1'b0;
            q_oe_r       <= 1'b0;
            busy_r       <= 1'b0;
            data_ready_r <= 1'b0;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 8'd0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    q_r    <= 1'b0;
                    q_oe_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (data_valid && data_ready_r && !abort) begin
                        state_r      <= SEND;
                        data_r       <= data;
                        frame_cnt_r  <= 8'd0;
                        half_cnt_r   <= '0;
                        half_r       <= 1'b0;
                        bit_r        <= 6'd0;
                        // Bit 0 is a header one and the biphase level starts at 0,
                        // so both codes open the frame with a high half.
                        q_r          <= 1'b1;
                        q_oe_r       <= 1'b1;
                        busy_r       <= 1'b1;
                        data_ready_r <= 1'b0;
                    end else begin
                        data_ready_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state_r      <= IDLE;
                        q_r          <= 1'b0;
                        q_oe_r       <= 1'b0;
                        busy_r       <= 1'b0;
                        data_ready_r <= 1'b1;
                    end else begin
                        half_cnt_r <= half_cnt_n_s;
                        half_r     <= half_n_s;
                        bit_r      <= bit_n_s;
                        if (next_last_s) begin
                            frame_done_r <= 1'b1;
                            frame_cnt_r  <= frame_cnt_r + 8'd1;
                        end
                        if (frame_end_s) begin
                            if (GAP_CLKS != 0) begin
                                state_r   <= GAP;
                                gap_cnt_r <= '0;
                                q_r       <= 1'b0;
                                q_oe_r    <= 1'b0;
                            end else if (reps_done_s) begin
                                state_r      <= IDLE;
                                q_r          <= 1'b0;
                                q_oe_r       <= 1'b0;
                                busy_r       <= 1'b0;
                                data_ready_r <= 1'b1;
                            end else begin
                                q_r <= q_code_s;
                            end
                        end else if (half_cnt_n_s == '0) begin
                            q_r <= q_code_s;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_r      <= IDLE;
                        q_r          <= 1'b0;
                        q_oe_r       <= 1'b0;
                        busy_r       <= 1'b0;
                        data_ready_r <= 1'b1;
                    end else if (gap_end_s) begin
                        if (reps_done_s) begin
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                            data_ready_r <= 1'b1;
                        end else begin
                            state_r    <= SEND;
                            half_cnt_r <= '0;
                            half_r     <= 1'b0;
                            bit_r      <= 6'd0;
                            q_r        <= 1'b1;
                            q_oe_r     <= 1'b1;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    q_r          <= 1'b0;
                    q_oe_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    data_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready = data_ready_r;
    assign q          = q_r;
    assign q_oe       = q_oe_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_em4100_tx.sv
// tb_em4100_tx: scoreboard bench for em4100_tx. Two instances share the
// stimulus: a Manchester one (3 clk/half-bit, 2 frames, 1-bit gap) and a
// continuous biphase one (1 clk/half-bit, no gap). Every load pushes the
// per-cycle expected waveform into a queue per instance; a negedge monitor
// pops and compares.
module tb_em4100_tx;

    localparam int HM   = 3;
    localparam int HB   = 1;
    localparam int GAPM = 2 * HM;

    typedef struct {
        bit oe;
        bit q;
        bit last;
        int cnt;
    } exp_t;

    typedef bit bitq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [39:0] data = 40'd0;
    logic        abort = 1'b0;

    logic        rdy_m, q_m, oe_m, busy_m, done_m;
    logic [7:0]  cnt_m;
    logic        rdy_b, q_b, oe_b, busy_b, done_b;
    logic [7:0]  cnt_b;

    exp_t qm[$];
    exp_t qb[$];
    int   seen_m = 0;
    int   seen_b = 0;
    bit   lvl_b  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    em4100_tx #(.HALF_BIT_CLKS(HM), .MODE(0), .REPEAT(2), .GAP_BITS(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_ready(rdy_m),
        .data(data), .abort(abort), .q(q_m), .q_oe(oe_m), .busy(busy_m),
        .frame_done(done_m), .frame_cnt(cnt_m)
    );

    em4100_tx #(.HALF_BIT_CLKS(HB), .MODE(1), .REPEAT(0), .GAP_BITS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_ready(rdy_b),
        .data(data), .abort(abort), .q(q_b), .q_oe(oe_b), .busy(busy_b),
        .frame_done(done_b), .frame_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame straight from the format rules, in transmit order.
    function automatic bitq_t model_frame(input logic [39:0] d);
        bitq_t       f;
        logic [39:0] t;
        int          ones;
        for (int i = 0; i < 9; i++) f.push_back(1'b1);
        for (int r = 0; r < 10; r++) begin
            t = d >> (36 - 4 * r);
            ones = 0;
            for (int k = 3; k >= 0; k--) begin
                f.push_back(t[k]);
                if (t[k]) ones++;
            end
            f.push_back((ones % 2) == 1);
        end
        for (int c = 3; c >= 0; c--) begin
            ones = 0;
            for (int r = 0; r < 10; r++) begin
                t = d >> (36 - 4 * r + c);
                if (t[0]) ones++;
            end
            f.push_back((ones % 2) == 1);
        end
        f.push_back(1'b0);
        return f;
    endfunction

    task automatic push_frame(input int which, input logic [39:0] d, input int cnt_before);
        bitq_t fb;
        exp_t  e;
        bit    v;
        int    h;
        fb = model_frame(d);
        h  = (which == 0) ? HM : HB;
        for (int b = 0; b < 64; b++) begin
            for (int hf = 0; hf < 2; hf++) begin
                if (which == 1) begin
                    if (hf == 0) lvl_b = ~lvl_b;
                    else if (!fb[b]) lvl_b = ~lvl_b;
                    v = lvl_b;
                end else begin
                    v = (hf == 1) ? ~fb[b] : fb[b];
                end
                for (int c = 0; c < h; c++) begin
                    e.oe   = 1'b1;
                    e.q    = v;
                    e.last = (b == 63) && (hf == 1) && (c == h - 1);
                    e.cnt  = e.last ? cnt_before + 1 : cnt_before;
                    if (which == 0) qm.push_back(e);
                    else qb.push_back(e);
                end
            end
        end
    endtask

    task automatic push_gap(input int cnt);
        exp_t e;
        e.oe = 1'b0; e.q = 1'b0; e.last = 1'b0; e.cnt = cnt;
        for (int i = 0; i < GAPM; i++) qm.push_back(e);
    endtask

    // Monitor: one expected entry per cycle while a DUT is active, idle otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (qm.size() > 0) begin
            e = qm.pop_front();
            chk("m_oe", oe_m, e.oe);
            chk("m_q", q_m, e.q);
            chk("m_busy", busy_m, 1);
            chk("m_done", done_m, e.last);
            chk("m_cnt", cnt_m, e.cnt);
            if (e.last) seen_m = e.cnt;
        end else begin
            chk("m_idle_oe", oe_m, 0);
            chk("m_idle_q", q_m, 0);
            chk("m_idle_busy", busy_m, 0);
            chk("m_idle_done", done_m, 0);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_oe", oe_b, e.oe);
            chk("b_q", q_b, e.q);
            chk("b_busy", busy_b, 1);
            chk("b_done", done_b, e.last);
            chk("b_cnt", cnt_b, e.cnt);
            if (e.last) seen_b = e.cnt;
        end else begin
            chk("b_idle_oe", oe_b, 0);
            chk("b_idle_q", q_b, 0);
            chk("b_idle_busy", busy_b, 0);
            chk("b_idle_done", done_b, 0);
        end
    end

    task automatic do_load(input logic [39:0] d);
        @(negedge clk);
        chk("m_ready_before_load", rdy_m, 1);
        chk("b_ready_before_load", rdy_b, 1);
        data       = d;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data       = {8'($urandom), $urandom};
        lvl_b  = 1'b0;
        seen_m = 0;
        seen_b = 0;
        push_frame(0, d, 0);
        push_gap(1);
        push_frame(0, d, 1);
        push_gap(2);
        for (int f = 0; f < 8; f++) push_frame(1, d, f);
        @(negedge clk);
        chk("m_ready_while_busy", rdy_m, 0);
        chk("b_ready_while_busy", rdy_b, 0);
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        qm.delete();
        qb.delete();
        @(negedge clk);
        chk("m_abort_busy", busy_m, 0);
        chk("m_abort_ready", rdy_m, 1);
        chk("m_abort_cnt", cnt_m, seen_m);
        chk("b_abort_busy", busy_b, 0);
        chk("b_abort_ready", rdy_b, 1);
        chk("b_abort_cnt", cnt_b, seen_b);
    endtask

    task automatic drain_m();
        int n;
        n = 0;
        while (qm.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("m_drain_timeout", qm.size(), 0);
        @(negedge clk);
        chk("m_repeat_cnt", cnt_m, 2);
        chk("m_repeat_ready", rdy_m, 1);
        chk("m_repeat_busy", busy_m, 0);
    endtask

    initial begin
        logic [39:0] d;

        // Reset values, then data_ready one cycle after release.
        repeat (3) @(negedge clk);
        chk("m_reset_ready", rdy_m, 0);
        chk("b_reset_ready", rdy_b, 0);
        chk("m_reset_cnt", cnt_m, 0);
        chk("b_reset_cnt", cnt_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("m_ready_after_reset", rdy_m, 1);
        chk("b_ready_after_reset", rdy_b, 1);

        for (int i = 0; i < 6; i++) begin
            if (i == 0)      d = 40'h0;
            else if (i == 1) d = 40'hF000000000;
            else             d = {8'($urandom), $urandom};
            do_load(d);
            if (i % 2 == 0 || i == 1) begin
                drain_m();
                do_abort();
            end else begin
                repeat (30 * 2 * HM + $urandom_range(0, 5)) @(negedge clk);
                do_abort();
            end
        end

        // abort together with data_valid in IDLE: load refused.
        @(negedge clk);
        abort      = 1'b1;
        data_valid = 1'b1;
        data       = {8'($urandom), $urandom};
        @(posedge clk);
        #1;
        abort      = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        chk("m_abort_load_ready", rdy_m, 1);
        chk("b_abort_load_ready", rdy_b, 1);
        repeat (4) @(negedge clk);

        // Reset mid-frame with a data_valid pulse while in reset.
        do_load({8'($urandom), $urandom});
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        qm.delete();
        qb.delete();
        @(negedge clk);
        data_valid = 1'b1;
        @(negedge clk);
        chk("m_midreset_ready", rdy_m, 0);
        chk("b_midreset_ready", rdy_b, 0);
        chk("m_midreset_cnt", cnt_m, 0);
        chk("b_midreset_cnt", cnt_b, 0);
        data_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        chk("m_ready_after_midreset", rdy_m, 1);
        chk("b_ready_after_midreset", rdy_b, 1);
        repeat (3) @(negedge clk);

        do_load({8'($urandom), $urandom});
        drain_m();
        do_abort();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/em4100_tx.md
Name: em4100_tx

Overview:
- Parametrised EM4100-format RFID tag transmitter: builds the 64-bit frame from a 40-bit ID (9-bit header, 10 rows of nibble plus even row parity, 4 column parities, stop bit).
- Serialises the frame with Manchester or biphase coding at a configurable clocks-per-half-bit rate.
- Repeats the frame a programmable number of times or continuously, with an optional inter-frame gap.
- Sits between the ID register/controller and the coil-driver modulation output. Adds a load handshake, abort, and status.

Parameters:
- HALF_BIT_CLKS, 32, clk cycles per half bit (≥1). Default is RF/64 when clk is the carrier.
- MODE, 0, line code: 0 = Manchester, 1 = biphase.
- REPEAT, 0, frames sent per load. 0 = continuous until abort.
- GAP_BITS, 0, bit periods of idle gap after each frame, with q_oe low.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- data_valid  in  1  ID load request
- data_ready  out  1  high only in IDLE
- data  in  40  tag ID. data[39:36] is the first row, sent MSB first.
- abort  in  1  synchronous stop request
- q  out  1  coded output level
- q_oe  out  1  modulator enable. Replaces tristate: downstream drives only when high.
- busy  out  1  high in SEND or GAP
- frame_done  out  1  one-cycle pulse per completed frame
- frame_cnt  out  8  frames completed since last load. Wraps at 255.

Behaviour:
- Reset (rst_n low at posedge): state IDLE, q=0, q_oe=0, busy=0, data_ready=0, frame_done=0, frame_cnt=0. data_ready rises the first cycle after rst_n returns high. Reset mid-frame truncates the output immediately on the next edge.
- States: IDLE, SEND, GAP.
- IDLE -> SEND on data_valid && data_ready (cycle T).
  - The frame is latched in T. Later changes on data are ignored until the next IDLE.
  - frame_cnt is cleared in T.
  - The first half of frame bit 0 drives q from T+1. q_oe=1 and busy=1 from T+1. data_ready=0 from T+1.
- Frame bit order, index 0 first:
  - bits 0–8 are 1.
  - Row r=0..9: 4 bits data[39-4r] down to data[36-4r], then the XOR of those 4 bits.
  - Bits 59–62: column parity CP3..CP0, where CPi = XOR over rows of nibble bit i.
  - Bit 63 = 0.
- Each bit lasts 2*HALF_BIT_CLKS cycles. A frame lasts 128*HALF_BIT_CLKS cycles.
- Manchester coding: first half = b, second half = ~b.
- Biphase coding:
  - q toggles at every bit boundary, and additionally at mid-bit when b=0.
  - The level is initialised to 0 on load, so the first half of bit 0 is 1.
  - The level is continuous across back-to-back frames.
- frame_done is high on the last clock of bit 63's second half. frame_cnt increments on the same edge.
- After a frame:
  - If GAP_BITS>0, go to GAP: q=0, q_oe=0, busy=1 for GAP_BITS*2*HALF_BIT_CLKS cycles.
  - Then, if REPEAT≠0 and frame_cnt has reached REPEAT, go to IDLE (busy=0, data_ready=1).
  - Otherwise start the next frame at bit 0 with no dead cycle.
  - With GAP_BITS=0, the next frame follows on the next clock.
  - Biphase level resets to 0 after a gap.
- abort sampled high in SEND or GAP: next cycle IDLE, q=0, q_oe=0, busy=0, data_ready=1. No frame_done is generated. frame_cnt is held.
- abort in IDLE has no effect. abort together with data_valid in IDLE: abort wins and the load is refused; data_ready stays 1.
- Counter widths are clog2-sized from the parameters. No counter may overflow at any legal parameter value.

Decomposition:
- Package em4100_pkg holds:
  - FRAME_BITS=64, HEADER_BITS=9, ROWS=10.
  - Mode constants MODE_MANCHESTER=0 and MODE_BIPHASE=1.
  - The state enum {IDLE, SEND, GAP}.
- Sub-module em4100_frame_build: purely combinational, data[39:0] -> frame[63:0] in transmit order. It is reusable by the future reader/decoder.
- em4100_tx holds the FSM, half-bit timer, bit index, line coder and counters.

Test Plan:
- HALF_BIT_CLKS=4, MODE=0, REPEAT=1, data=40'h0 -> q is 9×"10" then 55×"01", each half 4 cycles. frame_done fires at T+512. Then IDLE, frame_cnt=1.
- data=40'hF000000000, MODE=0, REPEAT=1 -> decoded bits are: 9 ones, 11110, 45 zeros, 1111, 0. The bench decoder must match this exactly.
- MODE=1, REPEAT=2, data=40'h0 -> biphase: q=1 for 8 cycles per header bit, alternating per bit. Each 0 bit shows a mid-bit toggle. Two frame_done pulses 512 cycles apart. The level is continuous at the frame boundary.
- REPEAT=0, GAP_BITS=2 -> q_oe low for 16 cycles between frames. frame_cnt counts 1,2,3. busy stays high throughout.
- abort asserted at frame bit 30 -> next cycle q_oe=0, busy=0, data_ready=1, no frame_done. A new load restarts at header bit 0.
- rst_n low mid-frame, then a data_valid pulse during reset -> all outputs at reset values. No load is accepted until data_ready=1.
